mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register plus writeback-select logic of the 16-bit CPU: the write-side end of the datapath.
//  The ALU-source path picks operands going into the ALU; this block picks the result going back to the register file.

---
 rtl/mem_wb_if.sv | 47 ++++
 rtl/mem_wb_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_if.sv
// MEM/WB stage bundle, data-memory read return and register-file writeback bus.
// Build option: WB_FWD_EN (the fwd_* group is only meaningful when it is defined).
// slave  : the mem_wb_stage side (consumes in_*/mem_*, drives wb_*/mem_wait/mem_err/fwd_*)
// master : the upstream/memory/regfile side
interface mem_wb_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
);
  // MEM-stage bundle and pipeline control
  logic          stall;
  logic          flush;
  logic          in_vld;
  logic [1:0]    in_wb_sel;
  logic [DW-1:0] in_alu_res;
  logic [DW-1:0] in_pc_inc;
  logic [DW-1:0] in_imm;
  logic [RW-1:0] in_rd;
  logic          in_reg_wr;
  logic          in_halt;
  // data-memory read return
  logic [DW-1:0] mem_rd_data;
  logic          mem_rd_vld;
  // stage outputs
  logic          mem_wait;
  logic          wb_we;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_halt;
  logic          mem_err;
  logic          fwd_vld;
  logic [RW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;

  modport slave (
    input  stall, flush, in_vld, in_wb_sel, in_alu_res, in_pc_inc, in_imm,
           in_rd, in_reg_wr, in_halt, mem_rd_data, mem_rd_vld,
    output mem_wait, wb_we, wb_rd, wb_data, wb_halt, mem_err,
           fwd_vld, fwd_rd, fwd_data
  );

  modport master (
    output stall, flush, in_vld, in_wb_sel, in_alu_res, in_pc_inc, in_imm,
           in_rd, in_reg_wr, in_halt, mem_rd_data, mem_rd_vld,
    input  mem_wait, wb_we, wb_rd, wb_data, wb_halt, mem_err,
           fwd_vld, fwd_rd, fwd_data
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback-select for the 16-bit CPU.
// Selects ALU result / memory data / PC+2 / immediate and drives the
// register-file write port; waits on multi-cycle loads with a timeout.
// Build option: define WB_FWD_EN to enable the fwd_* outputs and the
// same-cycle mem_rd_data bypass when a load leaves WAIT.
// Ports: clk, rst_n (async active-low), bus (mem_wb_if.slave):
//   in:  stall, flush, in_vld, in_wb_sel, in_alu_res, in_pc_inc, in_imm,
//        in_rd, in_reg_wr, in_halt, mem_rd_data, mem_rd_vld
//   out: mem_wait (combinational), wb_we, wb_rd, wb_data, wb_halt, mem_err,
//        fwd_vld, fwd_rd, fwd_data
module mem_wb_stage #(
  parameter int unsigned DW     = 16,
  parameter int unsigned RW     = 4,
  parameter int unsigned MEM_TO = 15
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_wb_if.slave  bus
);

  localparam int unsigned CW = 8;
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC  = 2'b10;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] pend_rd_q, pend_rd_d;
  logic          pend_wr_q, pend_wr_d;
  logic          pend_halt_q, pend_halt_d;
  logic          wb_we_q, wb_we_d;
  logic [RW-1:0] wb_rd_q, wb_rd_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          wb_halt_q, wb_halt_d;
  logic          mem_err_q, mem_err_d;
  logic          mem_wait_c;
  logic          accept_c;
  logic [DW-1:0] sel_data_c;

  // Once HLT has reached writeback every later bundle is ignored
  assign accept_c = bus.in_vld & ~bus.stall & ~bus.flush & ~wb_halt_q;

  // Writeback source mux for non-waiting bundles
  always_comb begin
    sel_data_c = bus.in_imm;
    case (bus.in_wb_sel)
      SEL_ALU: sel_data_c = bus.in_alu_res;
      SEL_MEM: sel_data_c = bus.mem_rd_data;
      SEL_PC:  sel_data_c = bus.in_pc_inc;
      default: sel_data_c = bus.in_imm;
    endcase
  end

  // Next-state and writeback register update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_rd_d   = pend_rd_q;
    pend_wr_d   = pend_wr_q;
    pend_halt_d = pend_halt_q;
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_halt_d   = wb_halt_q;
    mem_err_d   = mem_err_q;
    mem_wait_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (bus.in_wb_sel == SEL_MEM && !bus.mem_rd_vld) begin
            // The accept cycle counts as the first waiting cycle
            state_d     = S_WAIT;
            cnt_d       = CW'(1);
            pend_rd_d   = bus.in_rd;
            pend_wr_d   = bus.in_reg_wr;
            pend_halt_d = bus.in_halt;
            mem_wait_c  = 1'b1;
          end else begin
            wb_rd_d   = bus.in_rd;
            wb_data_d = sel_data_c;
            wb_we_d   = bus.in_reg_wr & (bus.in_rd != '0);
            wb_halt_d = wb_halt_q | bus.in_halt;
          end
        end
      end
      S_WAIT: begin
        // stall and flush are ignored here: the pending load always retires
        if (bus.mem_rd_vld) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          wb_rd_d   = pend_rd_q;
          wb_data_d = bus.mem_rd_data;
          wb_we_d   = pend_wr_q & (pend_rd_q != '0);
          wb_halt_d = wb_halt_q | pend_halt_q;
        end else if (cnt_q >= CW'(MEM_TO)) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          mem_err_d = 1'b1;
          wb_rd_d   = pend_rd_q;
          wb_data_d = '0;
          wb_we_d   = pend_wr_q & (pend_rd_q != '0);
          wb_halt_d = wb_halt_q | pend_halt_q;
        end else begin
          cnt_d      = cnt_q + CW'(1);
          mem_wait_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_rd_q   <= '0;
      pend_wr_q   <= 1'b0;
      pend_halt_q <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_halt_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_rd_q   <= pend_rd_d;
      pend_wr_q   <= pend_wr_d;
      pend_halt_q <= pend_halt_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_halt_q   <= wb_halt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign bus.mem_wait = mem_wait_c;
  assign bus.wb_we    = wb_we_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_halt  = wb_halt_q;
  assign bus.mem_err  = mem_err_q;

`ifdef WB_FWD_EN
  // Bypass load data straight to forwarding in the cycle it returns
  logic byp_c;
  assign byp_c        = (state_q == S_WAIT) & bus.mem_rd_vld;
  assign bus.fwd_vld  = byp_c ? (pend_wr_q & (pend_rd_q != '0)) : wb_we_q;
  assign bus.fwd_rd   = byp_c ? pend_rd_q : wb_rd_q;
  assign bus.fwd_data = byp_c ? bus.mem_rd_data : wb_data_q;
`else
  assign bus.fwd_vld  = 1'b0;
  assign bus.fwd_rd   = '0;
  assign bus.fwd_data = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: table of single-cycle bundles plus hand-written
// load, timeout, reset-in-WAIT and HLT sequences; registered writeback
// expectations go through a scoreboard queue.
module tb_mem_wb_stage;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
  localparam int unsigned MEM_TO = 15;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mem_wb_if #(.DW(DW), .RW(RW)) bus ();

  mem_wb_stage #(.DW(DW), .RW(RW), .MEM_TO(MEM_TO)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic          vld;
    logic [1:0]    sel;
    logic [DW-1:0] alu;
    logic [DW-1:0] pc;
    logic [DW-1:0] imm;
    logic [RW-1:0] rd;
    logic          wr;
    logic          stall;
    logic          flush;
    logic          mvld;
    logic [DW-1:0] mdata;
    logic          ewe;
    logic [RW-1:0] erd;
    logic [DW-1:0] edata;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.stall = 0; bus.flush = 0; bus.in_vld = 0; bus.in_wb_sel = 0;
    bus.in_alu_res = 0; bus.in_pc_inc = 0; bus.in_imm = 0; bus.in_rd = 0;
    bus.in_reg_wr = 0; bus.in_halt = 0; bus.mem_rd_data = 0; bus.mem_rd_vld = 0;
  endtask

  task automatic drive_bundle(input logic [1:0] sel, input logic [DW-1:0] val,
                              input logic [RW-1:0] rd, input logic wr, input logic halt);
    bus.in_vld = 1; bus.in_wb_sel = sel; bus.in_alu_res = val; bus.in_pc_inc = val;
    bus.in_imm = val; bus.in_rd = rd; bus.in_reg_wr = wr; bus.in_halt = halt;
  endtask

  // Pop the oldest expectation and compare against the registered outputs
  task automatic sb_check(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_we"},   32'(bus.wb_we),   32'(e.we));
      chk({nm, "_rd"},   32'(bus.wb_rd),   32'(e.rd));
      chk({nm, "_data"}, 32'(bus.wb_data), 32'(e.data));
    end
  endtask

  initial begin
    int waited;
    n_checks = 0;
    n_errors = 0;
    drive_idle();
    rst_n = 0;

    //            vld sel    alu      pc       imm      rd wr st fl mv mdata    we rd data
    vt[0] = '{1, 2'b00, 16'h1234, 16'h0,    16'h0,    3,  1, 0, 0, 0, 16'h0,    1, 3,  16'h1234};
    vt[1] = '{0, 2'b00, 16'h0,    16'h0,    16'h0,    0,  0, 0, 0, 0, 16'h0,    0, 3,  16'h1234};
    vt[2] = '{1, 2'b00, 16'hFFFF, 16'h0,    16'h0,    0,  1, 0, 0, 0, 16'h0,    0, 0,  16'hFFFF};
    vt[3] = '{1, 2'b10, 16'h0,    16'h0042, 16'h0,    7,  1, 1, 1, 0, 16'h0,    0, 0,  16'hFFFF};
    vt[4] = '{1, 2'b10, 16'h0,    16'h0042, 16'h0,    7,  1, 1, 0, 0, 16'h0,    0, 0,  16'hFFFF};
    vt[5] = '{1, 2'b10, 16'h0,    16'h0042, 16'h0,    7,  1, 0, 0, 0, 16'h0,    1, 7,  16'h0042};
    vt[6] = '{1, 2'b11, 16'h0,    16'h0,    16'hA5A5, 15, 1, 0, 0, 0, 16'h0,    1, 15, 16'hA5A5};
    vt[7] = '{1, 2'b00, 16'h0BAD, 16'h0,    16'h0,    2,  0, 0, 0, 0, 16'h0,    0, 2,  16'h0BAD};
    vt[8] = '{1, 2'b00, 16'h1111, 16'h0,    16'h0,    1,  1, 0, 1, 0, 16'h0,    0, 2,  16'h0BAD};
    vt[9] = '{1, 2'b01, 16'h0,    16'h0,    16'h0,    4,  1, 0, 0, 1, 16'h7777, 1, 4,  16'h7777};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(bus.wb_we), 0);
    chk("rst_rd", 32'(bus.wb_rd), 0);
    chk("rst_data", 32'(bus.wb_data), 0);
    chk("rst_halt", 32'(bus.wb_halt), 0);
    chk("rst_err", 32'(bus.mem_err), 0);
    chk("rst_wait", 32'(bus.mem_wait), 0);
    chk("rst_fwd", 32'(bus.fwd_vld), 0);
    @(negedge clk);
    rst_n = 1;

    // Single-cycle bundle table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_vld = vt[i].vld; bus.in_wb_sel = vt[i].sel; bus.in_alu_res = vt[i].alu;
      bus.in_pc_inc = vt[i].pc; bus.in_imm = vt[i].imm; bus.in_rd = vt[i].rd;
      bus.in_reg_wr = vt[i].wr; bus.stall = vt[i].stall; bus.flush = vt[i].flush;
      bus.mem_rd_vld = vt[i].mvld; bus.mem_rd_data = vt[i].mdata;
      sbq.push_back('{vt[i].ewe, vt[i].erd, vt[i].edata});
      #1 chk($sformatf("vec%0d_wait", i), 32'(bus.mem_wait), 0);
      @(posedge clk);
      #1 sb_check($sformatf("vec%0d", i));
`ifdef WB_FWD_EN
      chk($sformatf("vec%0d_fwd", i), 32'(bus.fwd_vld), 32'(vt[i].ewe));
`else
      chk($sformatf("vec%0d_fwd", i), 32'(bus.fwd_vld), 0);
`endif
    end
    @(negedge clk);
    drive_idle();

    // Load with 3-cycle memory; stall/flush during WAIT must not abort it
    @(negedge clk);
    drive_bundle(2'b01, 16'h0, 5, 1, 0);
    #1 chk("ld_wait0", 32'(bus.mem_wait), 1);
    @(posedge clk);
    #1 chk("ld_we0", 32'(bus.wb_we), 0);
    @(negedge clk);
    drive_idle();
    bus.stall = 1; bus.flush = 1;
    #1 chk("ld_wait1", 32'(bus.mem_wait), 1);
    @(posedge clk);
    #1 chk("ld_we1", 32'(bus.wb_we), 0);
    @(negedge clk);
    drive_idle();
    #1 chk("ld_wait2", 32'(bus.mem_wait), 1);
    @(negedge clk);
    bus.mem_rd_vld = 1; bus.mem_rd_data = 16'hBEEF;
    sbq.push_back('{1'b1, 4'd5, 16'hBEEF});
    #1 chk("ld_wait3", 32'(bus.mem_wait), 0);
    @(posedge clk);
    #1 sb_check("ld");
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1 chk("ld_pulse", 32'(bus.wb_we), 0);

    // Timeout: memory never answers
    @(negedge clk);
    drive_bundle(2'b01, 16'h0, 6, 1, 0);
    waited = 0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (!bus.mem_wait) break;
      waited++;
      @(negedge clk);
      drive_idle();
      #1;
    end
    chk("to_wait_cycles", 32'(waited), 32'(MEM_TO));
    @(posedge clk);
    #1 chk("to_err", 32'(bus.mem_err), 1);
    chk("to_data", 32'(bus.wb_data), 0);
    chk("to_rd", 32'(bus.wb_rd), 6);
    chk("to_wait_low", 32'(bus.mem_wait), 0);
    @(negedge clk);
    drive_bundle(2'b00, 16'h5555, 9, 1, 0);
    sbq.push_back('{1'b1, 4'd9, 16'h5555});
    #1 chk("to_idle_wait", 32'(bus.mem_wait), 0);
    @(posedge clk);
    #1 sb_check("to_next");
    chk("to_err_sticky", 32'(bus.mem_err), 1);

    // Reset during WAIT drops the load and clears mem_err
    @(negedge clk);
    drive_bundle(2'b01, 16'h0, 8, 1, 0);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    #1 chk("rw_wait", 32'(bus.mem_wait), 1);
    rst_n = 0;
    #1;
    chk("rw_we", 32'(bus.wb_we), 0);
    chk("rw_rd", 32'(bus.wb_rd), 0);
    chk("rw_data", 32'(bus.wb_data), 0);
    chk("rw_err", 32'(bus.mem_err), 0);
    chk("rw_wait_low", 32'(bus.mem_wait), 0);
    chk("rw_halt", 32'(bus.wb_halt), 0);
    @(negedge clk);
    rst_n = 1;
    bus.mem_rd_vld = 1; bus.mem_rd_data = 16'hBEEF;
    @(posedge clk);
    #1 chk("rw_dropped_we", 32'(bus.wb_we), 0);
    chk("rw_dropped_data", 32'(bus.wb_data), 0);

    // HLT latches and blocks later bundles
    @(negedge clk);
    drive_idle();
    drive_bundle(2'b00, 16'h0, 0, 0, 1);
    @(posedge clk);
    #1 chk("hlt_set", 32'(bus.wb_halt), 1);
    @(negedge clk);
    drive_idle();
    repeat (3) @(posedge clk);
    #1 chk("hlt_held", 32'(bus.wb_halt), 1);
    @(negedge clk);
    drive_bundle(2'b00, 16'h9999, 3, 1, 0);
    @(posedge clk);
    #1 chk("hlt_block_we", 32'(bus.wb_we), 0);
    chk("hlt_block_data", 32'(bus.wb_data), 0);
    chk("hlt_still", 32'(bus.wb_halt), 1);
    @(negedge clk);
    drive_idle();

    chk("sb_drained", 32'(sbq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
